// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, word stride
// and default widths.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int LEN_W_DEF     = 8;
  localparam int CPU_QUOTA_DEF = 4;
  localparam int WORD_STRIDE   = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CPU_RD    = 2'd1,
    EXT_BURST = 2'd2,
    EXT_DRAIN = 2'd3
  } arb_state_t;

endpackage

// File: rtl/dmem_arb_burst_ctr.sv
// EXT burst address/beat tracker: loads base and length, then advances one
// word per step and flags the final beat.
module dmem_arb_burst_ctr
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] addr_reg;
  logic [LEN_W-1:0]  count_reg;

  // A zero length request still moves one beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_reg  <= '0;
      count_reg <= '0;
    end else if (load) begin
      addr_reg  <= base;
      count_reg <= (len == '0) ? LEN_W'(1) : len;
    end else if (step) begin
      addr_reg  <= addr_reg + ADDR_W'(WORD_STRIDE);
      count_reg <= count_reg - LEN_W'(1);
    end
  end

  assign addr = addr_reg;
  assign last = (count_reg == LEN_W'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the MEM stage and the EXT loader.
// Define DMEM_ARB_PERF_EN to enable the stall / EXT-beat performance counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int CPU_QUOTA = CPU_QUOTA_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [LEN_W-1:0]  ext_len,
  output logic              ext_gnt,
  output logic              ext_ready,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic              ext_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       perf_cpu_stall,
  output logic [31:0]       perf_ext_beats
);

  localparam int QW = $clog2(CPU_QUOTA + 1);

  arb_state_t        state_reg, state_next;
  logic [QW-1:0]     quota_reg;
  logic              we_reg, rd_pend_reg, done_reg;
  logic              ext_win, cpu_win, burst_load, burst_step, burst_last;
  logic [ADDR_W-1:0] burst_addr;

  assign ext_win    = ext_req && (!cpu_req || quota_reg == QW'(CPU_QUOTA));
  assign cpu_win    = cpu_req && !ext_win;
  assign burst_load = (state_reg == IDLE) && ext_win;
  assign burst_step = (state_reg == EXT_BURST);

  dmem_arb_burst_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_burst_ctr (
    .clock (clock),
    .reset (reset),
    .load  (burst_load),
    .step  (burst_step),
    .base  (ext_addr),
    .len   (ext_len),
    .addr  (burst_addr),
    .last  (burst_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (ext_win)                 state_next = EXT_BURST;
        else if (cpu_win && !cpu_we) state_next = CPU_RD;
      end
      CPU_RD:    state_next = IDLE;
      EXT_BURST: if (burst_last) state_next = we_reg ? IDLE : EXT_DRAIN;
      EXT_DRAIN: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Quota only counts CPU wins that actually made a waiting EXT request wait.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      quota_reg   <= '0;
      we_reg      <= 1'b0;
      rd_pend_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      if (burst_load)
        quota_reg <= '0;
      else if (state_reg == IDLE && cpu_win && ext_req && quota_reg != QW'(CPU_QUOTA))
        quota_reg <= quota_reg + QW'(1);
      if (burst_load) we_reg <= ext_we;
      rd_pend_reg <= burst_step && !we_reg;
      done_reg    <= burst_step && burst_last && we_reg;
    end
  end

  always_comb begin
    cpu_rdata  = '0;
    cpu_rvalid = 1'b0;
    cpu_stall  = 1'b0;
    ext_gnt    = 1'b0;
    ext_ready  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    ext_rvalid = rd_pend_reg;
    ext_rdata  = rd_pend_reg ? mem_rdata : '0;
    ext_done   = done_reg || (state_reg == EXT_DRAIN);
    case (state_reg)
      IDLE: begin
        if (ext_win) begin
          ext_gnt   = 1'b1;
          cpu_stall = cpu_req;
        end else if (cpu_req) begin
          mem_en    = 1'b1;
          mem_we    = cpu_we;
          mem_addr  = cpu_addr;
          mem_wdata = cpu_we ? cpu_wdata : '0;
          cpu_stall = !cpu_we;
        end
      end
      CPU_RD: begin
        cpu_rdata  = mem_rdata;
        cpu_rvalid = 1'b1;
      end
      EXT_BURST: begin
        cpu_stall = cpu_req;
        ext_ready = 1'b1;
        mem_en    = 1'b1;
        mem_we    = we_reg;
        mem_addr  = burst_addr;
        mem_wdata = we_reg ? ext_wdata : '0;
      end
      EXT_DRAIN: cpu_stall = cpu_req;
      default: ;
    endcase
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_reg, perf_beats_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_stall_reg <= '0;
      perf_beats_reg <= '0;
    end else begin
      if (cpu_stall && perf_stall_reg != '1) perf_stall_reg <= perf_stall_reg + 32'd1;
      if (ext_ready && perf_beats_reg != '1) perf_beats_reg <= perf_beats_reg + 32'd1;
    end
  end

  assign perf_cpu_stall = perf_stall_reg;
  assign perf_ext_beats = perf_beats_reg;
`else
  assign perf_cpu_stall = '0;
  assign perf_ext_beats = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter with a word-array memory
// and a transaction-level reference of memory contents and arbitration rules.
module tb_dmem_arbiter;

  localparam int CPU_QUOTA = 4;

  logic        clock, reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_rvalid, cpu_stall;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr;
  logic [7:0]  ext_len;
  logic        ext_gnt, ext_ready, ext_rvalid, ext_done;
  logic [31:0] ext_wdata, ext_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] perf_cpu_stall, perf_ext_beats;

  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_data;
  logic [31:0] burst_data [0:15];
  logic        burst_fin;
  int          n_checks, n_errors;

  dmem_arbiter #(.CPU_QUOTA(CPU_QUOTA)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_len(ext_len),
    .ext_gnt(ext_gnt), .ext_ready(ext_ready), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid), .ext_done(ext_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .perf_cpu_stall(perf_cpu_stall), .perf_ext_beats(perf_ext_beats)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port synchronous memory, word-indexed by byte address bits [9:2].
  always @(posedge clock) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cpu_store(input logic [31:0] addr, input logic [31:0] data);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = addr; cpu_wdata = data;
    @(negedge clock);
    check("store_stall", cpu_stall, 0);
    check("store_mem_en", mem_en, 1);
    check("store_mem_we", mem_we, 1);
    check("store_addr", mem_addr, addr);
    check("store_wdata", mem_wdata, data);
    @(posedge clock); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
    ref_mem[addr[9:2]] = data;
    $display("store addr=0x%08h data=0x%08h", addr, data);
  endtask

  task automatic cpu_load(input logic [31:0] addr, input int exp_stalls, output logic [31:0] data);
    int   stalls;
    logic got;
    stalls = 0; got = 1'b0; data = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr; cpu_wdata = $urandom;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clock);
      if (cpu_rvalid) begin
        got  = 1'b1;
        data = cpu_rdata;
        check("load_data", cpu_rdata, ref_mem[addr[9:2]]);
        check("load_rv_stall", cpu_stall, 0);
      end else if (cpu_stall) stalls++;
      else check("load_progress", cpu_stall, 1);
      @(posedge clock); #1;
    end
    cpu_req = 1'b0;
    check("load_done", got, 1);
    if (exp_stalls >= 0) check("load_stalls", stalls, exp_stalls);
    $display("load  addr=0x%08h data=0x%08h stalls=%0d", addr, data, stalls);
  endtask

  task automatic ext_burst(input logic we, input logic [31:0] base, input logic [7:0] len);
    int          n;
    logic        got;
    logic [31:0] a, prev;
    n = (len == 0) ? 1 : int'(len);
    got = 1'b0; prev = base;
    ext_req = 1'b1; ext_we = we; ext_addr = base; ext_len = len;
    for (int t = 0; t < 64 && !got; t++) begin
      @(negedge clock);
      if (ext_gnt) begin
        got = 1'b1;
        check("gnt_mem_en", mem_en, 0);
      end
      @(posedge clock); #1;
    end
    ext_req = 1'b0;
    check("ext_gnt", got, 1);
    if (got) begin
      for (int k = 0; k < n; k++) begin
        a = base + 32'(4 * k);
        ext_wdata = burst_data[k];
        @(negedge clock);
        if (k == 0) check("gnt_pulse", ext_gnt, 0);
        check("beat_ready", ext_ready, 1);
        check("beat_addr", mem_addr, a);
        check("beat_we", mem_we, we);
        check("beat_done", ext_done, 0);
        if (we) check("beat_wdata", mem_wdata, burst_data[k]);
        if (!we && k > 0) begin
          check("beat_rvalid", ext_rvalid, 1);
          check("beat_rdata", ext_rdata, ref_mem[prev[9:2]]);
        end
        @(posedge clock); #1;
        if (we) ref_mem[a[9:2]] = burst_data[k];
        prev = a;
      end
      ext_wdata = '0;
      @(negedge clock);
      check("burst_done", ext_done, 1);
      check("burst_end_ready", ext_ready, 0);
      if (!we) begin
        check("drain_rvalid", ext_rvalid, 1);
        check("drain_rdata", ext_rdata, ref_mem[prev[9:2]]);
      end
      burst_fin = 1'b1;
      @(posedge clock); #1;
    end else burst_fin = 1'b1;
    $display("burst we=%0b base=0x%08h len=%0d", we, base, len);
  endtask

  // EXT burst raced against a continuous stream of CPU stores.
  task automatic contention(input logic we, input logic [31:0] base, input logic [7:0] len);
    int   grants, budget;
    logic gnt_obs, stalled;
    grants = 0; budget = 0; gnt_obs = 1'b0; stalled = 1'b0; burst_fin = 1'b0;
    fork
      ext_burst(we, base, len);
      begin
        while (!burst_fin && budget < 300) begin
          cpu_req = 1'b1; cpu_we = 1'b1;
          cpu_addr = $urandom & 32'hFFFF_FFFC; cpu_wdata = $urandom;
          stalled = 1'b1;
          while (stalled && budget < 300) begin
            @(negedge clock);
            if (ext_gnt) gnt_obs = 1'b1;
            stalled = cpu_stall;
            if (!stalled && !gnt_obs) grants++;
            @(posedge clock); #1;
            budget++;
          end
          if (!stalled) ref_mem[cpu_addr[9:2]] = cpu_wdata;
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
      end
    join
    check("quota_grants", grants, CPU_QUOTA);
    $display("contention grants_before_gnt=%0d", grants);
  endtask

  logic [31:0] ld;
  int          op;

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b1; pre_we = 1'b0; pre_idx = '0; pre_data = '0; burst_fin = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_len = 0; ext_wdata = 0;
    @(posedge clock); #1;
    for (int i = 0; i < 256; i++) begin
      pre_we = 1'b1; pre_idx = 8'(i);
      pre_data = (i == 4) ? 32'h0000_1234 : $urandom;
      ref_mem[i] = pre_data;
      @(posedge clock); #1;
    end
    pre_we = 1'b0;
    @(negedge clock);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_cpu_stall", cpu_stall, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_ext_gnt", ext_gnt, 0);
    check("rst_ext_ready", ext_ready, 0);
    check("rst_ext_done", ext_done, 0);
    check("rst_ext_rvalid", ext_rvalid, 0);
    check("rst_perf", perf_cpu_stall | perf_ext_beats, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    cpu_load(32'h10, 1, ld);
    check("load_0x10", ld, 32'h1234);
    cpu_store(32'h20, 32'hCAFE);
    cpu_load(32'h20, 1, ld);
    check("load_0x20", ld, 32'hCAFE);

    burst_data[0] = 7; burst_data[1] = 3; burst_data[2] = 9; burst_data[3] = 1;
    burst_fin = 1'b0;
    fork
      ext_burst(1'b1, 32'h100, 8'd4);
      begin
        repeat (2) @(posedge clock);
        #1;
        cpu_load(32'h108, -1, ld);
      end
    join
    check("midburst_load", ld, 32'd9);

    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) burst_data[k] = $urandom;
      contention(1'b1, 32'h300, 8'd3);
    end

    ext_burst(1'b0, 32'hFFFF_FFFC, 8'd0);
    ext_burst(1'b0, 32'hFFFF_FFFC, 8'd2);

    // Reset lands in the third beat of an 8-beat write burst.
    for (int k = 0; k < 8; k++) burst_data[k] = $urandom;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h200; ext_len = 8'd8;
    @(negedge clock);
    check("rb_gnt", ext_gnt, 1);
    @(posedge clock); #1;
    ext_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ext_wdata = burst_data[k];
      @(posedge clock); #1;
      ref_mem[8'd128 + 8'(k)] = burst_data[k];
    end
    ext_wdata = burst_data[2];
    #2;
    check("rb_beat3_ready", ext_ready, 1);
    reset = 1'b1;
    #1;
    check("rb_mem_en", mem_en, 0);
    check("rb_mem_addr", mem_addr, 0);
    check("rb_ext_ready", ext_ready, 0);
    check("rb_ext_done", ext_done, 0);
    check("rb_ext_rvalid", ext_rvalid, 0);
    @(posedge clock); #1;
    reset = 1'b0; ext_wdata = '0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clock);
      check("rb_no_done", ext_done, 0);
      check("rb_idle", ext_ready, 0);
      @(posedge clock); #1;
    end
    $display("reset mid-burst at beat 3");
    ext_burst(1'b1, 32'h200, 8'd8);
    cpu_load(32'h208, 1, ld);
    check("rb_rewrite", ld, burst_data[2]);

    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 4));
      for (int k = 0; k < 16; k++) burst_data[k] = $urandom;
      burst_fin = 1'b0;
      case (op)
        0: cpu_store($urandom & 32'hFFFF_FFFC, $urandom);
        1: cpu_load($urandom & 32'hFFFF_FFFC, 1, ld);
        2: ext_burst(1'b1, $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 6)));
        3: ext_burst(1'b0, $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 6)));
        default: contention(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                            8'($urandom_range(0, 6)));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port synchronous data memory between the pipeline MEM stage (CPU) and an external host loader/reader (EXT). EXT streams merge-sort input arrays into memory and reads sorted results back. The block drives the memory port, returns read data and raises cpu_stall to freeze the pipeline while the CPU access is not yet served. It sits between EX_MEM/MEM_WB and the data memory.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, word width
LEN_W, 8, EXT burst length field width
CPU_QUOTA, 4, consecutive CPU grants allowed while EXT is pending before EXT is forced in

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  MEM stage has a load/store (lw | EscMem)
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  DATA_W  store data
cpu_rdata  out  DATA_W  load data, valid with cpu_rvalid
cpu_rvalid  out  1  load data valid pulse
cpu_stall  out  1  hold IF/ID/EX/MEM registers and PC
ext_req  in  1  burst request, held until ext_gnt
ext_we  in  1  burst direction
ext_addr  in  ADDR_W  burst base byte address
ext_len  in  LEN_W  beat count; 0 treated as 1
ext_gnt  out  1  one-cycle pulse, burst accepted
ext_ready  out  1  write beat consumed or read beat issued this cycle
ext_wdata  in  DATA_W  write beat data, sampled when ext_ready=1
ext_rdata  out  DATA_W  read beat data
ext_rvalid  out  1  read beat valid
ext_done  out  1  one-cycle pulse after the last beat completes
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory byte address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, 1-cycle latency

Behaviour:
- Reset (asynchronous): state IDLE, all outputs 0, quota counter 0, beat counter 0. An in-flight burst is aborted without ext_done.
- States: IDLE, CPU_RD, EXT_BURST, EXT_DRAIN.
- IDLE arbitration:
  - EXT wins if ext_req & (!cpu_req | quota==CPU_QUOTA). Otherwise CPU wins if cpu_req.
  - Quota counter increments on each CPU grant while ext_req=1, saturates at CPU_QUOTA, and clears on ext_gnt.
- CPU store granted in IDLE:
  - Same cycle: mem_en=1, mem_we=1, addr/data passed through, cpu_stall=0.
  - Stay in IDLE.
- CPU load granted in IDLE:
  - Issue cycle: mem_en=1, mem_we=0, cpu_stall=1, next state CPU_RD.
  - CPU_RD: cpu_rdata=mem_rdata, cpu_rvalid=1, cpu_stall=0, return to IDLE. Total load latency is 1 stall cycle.
- EXT granted in IDLE:
  - ext_gnt=1 and the CPU is not served, so cpu_stall=cpu_req.
  - Latch base, direction and len (0→1) into the beat counter. Next state EXT_BURST.
- EXT_BURST, one beat per cycle:
  - Each cycle: ext_ready=1, mem_en=1, mem_we=ext_we latched, mem_addr=base+4*beat.
  - Address wraps modulo 2^ADDR_W.
  - Write beats take mem_wdata=ext_wdata.
  - Read beat k data appears as ext_rdata/ext_rvalid in the following cycle.
  - After the last beat, a write burst returns to IDLE with ext_done=1 in that return cycle. A read burst goes to EXT_DRAIN.
- EXT_DRAIN: final ext_rvalid=1 and ext_done=1, then IDLE.
- cpu_stall=cpu_req whenever the state is not IDLE/CPU_RD, or whenever IDLE grants EXT.
- cpu_req must stay stable while cpu_stall=1. The pipeline flush (jumpTaked) never lands on a stalled MEM access.
- Simultaneous cpu_req and ext_req with quota<CPU_QUOTA: CPU wins and EXT waits. Back-to-back CPU loads cost 1 stall each.
- Memory outputs are 0 when mem_en=0.

Optional Feature:
DMEM_ARB_PERF_EN: adds two 32-bit saturating counters, perf_cpu_stall (cycles with cpu_stall=1) and perf_ext_beats (EXT beats issued). Both are cleared by reset and exposed as output ports. Without the macro, the ports still exist and are tied to 0, with no counter logic.

Decomposition:
- Package dmem_arb_pkg: state encoding (IDLE, CPU_RD, EXT_BURST, EXT_DRAIN), word stride constant 4, and the default widths.
- One sub-module, dmem_arb_burst_ctr: holds base address and remaining-beat count, and provides load, step, last and address outputs.

Test Plan:
- CPU load only: cpu_req=1, we=0, addr=0x10, mem word 0x1234 → cpu_stall=1 for 1 cycle, then cpu_rvalid=1 with cpu_rdata=0x1234.
- CPU store: addr=0x20, data=0xCAFE → mem_we=1 in the same cycle, cpu_stall never rises, later load returns 0xCAFE.
- EXT write burst: base=0x100, len=4, data 7,3,9,1 → addresses 0x100..0x10C, ext_done after 4 beats. CPU load to 0x108 issued mid-burst stalls, then returns 9.
- Starvation: cpu_req held continuously (stores) with ext_req=1, CPU_QUOTA=4 → exactly 4 CPU grants, then ext_gnt, and the quota counter is 0 after the grant.
- EXT read burst len=0 at 0xFFFFFFFC → treated as 1 beat, ext_rvalid once, ext_done in EXT_DRAIN. A len=2 burst from the same base wraps to address 0x0.
- Reset asserted during the 3rd beat of a len=8 burst → immediate IDLE, all outputs 0, no ext_done. A new burst afterward completes normally.
